// File: rtl/adc0809_responder.sv
// adc0809_responder
//   Cycle-accurate stand-in for an ADC0809-style 8-channel, 8-bit
//   successive-approximation converter. It answers the ale/start/oe
//   handshake from the AD control FSM. It drives eoc and the conversion
//   result. The analog inputs are modelled as eight 8-bit sample words.
//
// Ports
//   clk     in   system clock, all activity on posedge
//   rst_n   in   synchronous active-low reset
//   ale     in   address latch enable; addr is captured on its rising edge
//   start   in   rising edge resets the converter, falling edge starts it
//   oe      in   output enable; gates the result onto dout
//   addr    in   [2:0] channel select
//   ain     in   [8*CH_W-1:0] channel samples, channel i at ain[8i+7:8i]
//   eoc     out  high = idle/done, low = conversion pending or running
//   dout    out  [CH_W-1:0] result while oe=1, else zero
//   ch_sel  out  [2:0] currently latched channel address
module adc0809_responder #(
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned CH_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ale,
  input  logic              start,
  input  logic              oe,
  input  logic [2:0]        addr,
  input  logic [8*CH_W-1:0] ain,
  output logic              eoc,
  output logic [CH_W-1:0]   dout,
  output logic [2:0]        ch_sel
);

  localparam int unsigned     CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CH_W-1:0]  TRIAL_MSB = {1'b1, {(CH_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CONV,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              ale_prev_q, start_prev_q;
  logic [2:0]        ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]   vin_q, vin_d;
  logic [CH_W-1:0]   trial_q, trial_d;
  logic [CH_W-1:0]   sar_q, sar_d;
  logic [2:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   result_q, result_d;
  logic              eoc_q, eoc_d;

  logic              ale_rise, start_rise, start_fall;
  logic [CH_W-1:0]   ain_sel;
  logic [CH_W-1:0]   sar_try, sar_dec;

  assign ale_rise   =  ale   & ~ale_prev_q;
  assign start_rise =  start & ~start_prev_q;
  assign start_fall = ~start &  start_prev_q;

  // The sample/hold mux reads the channel that was latched before this edge.
  // So an ale rise on the start-fall edge cannot redirect that conversion.
  always_comb begin
    ain_sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (ch_sel_q == 3'(i)) ain_sel = ain[i*CH_W +: CH_W];
    end
  end

  // One SAR decision: keep the trial bit if the resulting code does not
  // exceed the held input.
  assign sar_try = sar_q | trial_q;
  assign sar_dec = (sar_try <= vin_q) ? sar_try : sar_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ale_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      ch_sel_q     <= '0;
      vin_q        <= '0;
      trial_q      <= '0;
      sar_q        <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      eoc_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      ale_prev_q   <= ale;
      start_prev_q <= start;
      ch_sel_q     <= ch_sel_d;
      vin_q        <= vin_d;
      trial_q      <= trial_d;
      sar_q        <= sar_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      eoc_q        <= eoc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    vin_d    = vin_q;
    trial_d  = trial_q;
    sar_d    = sar_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    eoc_d    = eoc_q;

    if (ale_rise) ch_sel_d = addr;

    case (state_q)
      S_IDLE, S_DONE: begin
        eoc_d = 1'b1;
        if (start_rise) begin
          state_d = S_ARMED;
          eoc_d   = 1'b0;
        end
      end

      S_ARMED: begin
        eoc_d = 1'b0;
        if (start_fall) begin
          state_d = S_CONV;
          vin_d   = ain_sel;
          trial_d = TRIAL_MSB;
          sar_d   = '0;
          bit_d   = 3'd7;
          cnt_d   = '0;
        end
      end

      S_CONV: begin
        eoc_d = 1'b0;
        if (start_rise) begin
          // Abort: re-arm without touching the committed result.
          state_d = S_ARMED;
        end else if (cnt_q == CNT_LAST) begin
          sar_d   = sar_dec;
          trial_d = trial_q >> 1;
          bit_d   = bit_q - 3'd1;
          cnt_d   = '0;
          if (bit_q == 3'd0) begin
            result_d = sar_dec;
            eoc_d    = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        eoc_d   = 1'b1;
      end
    endcase
  end

  assign eoc    = eoc_q;
  assign ch_sel = ch_sel_q;
  assign dout   = oe ? result_q : '0;

endmodule

// File: tb/tb_adc0809_responder.sv
module tb_adc0809_responder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ale   = 1'b0;
  logic        start = 1'b0;
  logic        oe    = 1'b0;
  logic [2:0]  addr  = 3'd0;
  logic [63:0] ain   = '0;
  logic        eoc;
  logic [7:0]  dout;
  logic [2:0]  ch_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc0809_responder #(.STEP_CYCLES(8), .CH_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ale(ale), .start(start), .oe(oe),
    .addr(addr), .ain(ain), .eoc(eoc), .dout(dout), .ch_sel(ch_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int unsigned ch, input logic [7:0] v);
    ain[ch*8 +: 8] = v;
  endtask

  // Controller sequence: latch addr, raise start, drop start.
  // The task returns right after the start-fall edge.
  task automatic launch(input logic [2:0] a, output logic eoc_armed);
    addr = a; ale = 1'b1; tick();
    ale = 1'b0; start = 1'b1; tick();
    eoc_armed = eoc;
    start = 1'b0; tick();
  endtask

  // Counts edges until eoc goes high. The count is bounded so that a stuck
  // DUT shows up as a wrong count.
  task automatic wait_eoc(output int edges);
    edges = 0;
    while (eoc !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      ale = 1'($urandom); start = 1'($urandom); oe = 1'($urandom);
      addr = 3'($urandom); ain = {$urandom, $urandom};
      tick();
    end
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc: got %b expected 1", eoc); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    ale = 0; start = 0; oe = 0; addr = 0; ain = '0;
    tick();
    rst_n = 1'b1;
    tick();
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout_oe: got %h expected 00", dout); end
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc_released: got %b expected 1", eoc); end
    oe = 1'b0;
  endtask

  task automatic test_basic();
    logic ea; int n;
    ain = '0; set_ch(3, 8'hA5);
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL basic_idle_eoc: got %b expected 1", eoc); end
    launch(3'd3, ea);
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL basic_eoc_fall: got %b expected 0", ea); end
    wait_eoc(n);
    checks++; if (n != 64) begin errors++; $display("FAIL basic_latency: got %0d expected 64", n); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL basic_dout_gated: got %h expected 00", dout); end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h expected a5", dout); end
    checks++; if (ch_sel !== 3'd3) begin errors++; $display("FAIL basic_ch_sel: got %0d expected 3", ch_sel); end
    oe = 1'b0;
  endtask

  task automatic test_all_channels();
    logic ea; int n;
    logic [7:0] exp_tab [8] = '{8'h3C, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    ain = {8'hFF, 8'h80, 8'h7F, 8'h01, 8'h00, 8'h55, 8'hAA, 8'h3C};
    for (int ch = 0; ch < 8; ch++) begin
      launch(3'(ch), ea);
      wait_eoc(n);
      checks++; if (n != 64) begin errors++; $display("FAIL allch_latency ch%0d: got %0d expected 64", ch, n); end
      oe = 1'b1; #1;
      checks++; if (dout !== exp_tab[ch]) begin errors++; $display("FAIL allch_dout ch%0d: got %h expected %h", ch, dout, exp_tab[ch]); end
      oe = 1'b0;
    end
  endtask

  task automatic test_sample_hold();
    logic ea; int n;
    ain = '0; set_ch(2, 8'h40);
    launch(3'd2, ea);
    repeat (20) tick();
    set_ch(2, 8'hC0);
    addr = 3'd7; ale = 1'b1; tick();
    ale = 1'b0;
    wait_eoc(n);
    checks++; if (n + 21 != 64) begin errors++; $display("FAIL hold_latency: got %0d expected 64", n + 21); end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h40) begin errors++; $display("FAIL hold_dout: got %h expected 40", dout); end
    checks++; if (ch_sel !== 3'd7) begin errors++; $display("FAIL hold_ch_sel: got %0d expected 7", ch_sel); end
    oe = 1'b0;
  endtask

  task automatic test_abort();
    logic ea; int n; logic glitch;
    glitch = 1'b0;
    set_ch(5, 8'h55);
    launch(3'd5, ea);
    repeat (30) begin tick(); if (eoc !== 1'b0) glitch = 1'b1; end
    start = 1'b1; tick();
    if (eoc !== 1'b0) glitch = 1'b1;
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h40) begin errors++; $display("FAIL abort_prev_held: got %h expected 40", dout); end
    oe = 1'b0;
    set_ch(5, 8'h99);
    start = 1'b0; tick();
    if (eoc !== 1'b0) glitch = 1'b1;
    repeat (10) begin tick(); if (eoc !== 1'b0) glitch = 1'b1; end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h40) begin errors++; $display("FAIL abort_prev_held_conv: got %h expected 40", dout); end
    oe = 1'b0;
    wait_eoc(n);
    checks++; if (glitch !== 1'b0) begin errors++; $display("FAIL abort_eoc_glitch: got %b expected 0", glitch); end
    checks++; if (n + 10 != 64) begin errors++; $display("FAIL abort_latency: got %0d expected 64", n + 10); end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h99) begin errors++; $display("FAIL abort_dout: got %h expected 99", dout); end
    oe = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ea; int n;
    set_ch(1, 8'hC3);
    launch(3'd1, ea);
    repeat (40) tick();
    rst_n = 1'b0; tick();
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL rstmid_eoc: got %b expected 1", eoc); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL rstmid_ch_sel: got %0d expected 0", ch_sel); end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h expected 00", dout); end
    oe = 1'b0;
    rst_n = 1'b1;
    repeat (70) tick();
    oe = 1'b1; #1;
    checks++; if (eoc !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL rstmid_idle: got eoc=%b dout=%h expected eoc=1 dout=00", eoc, dout); end
    oe = 1'b0;
    set_ch(0, 8'h5A);
    launch(3'd0, ea);
    wait_eoc(n);
    checks++; if (n != 64) begin errors++; $display("FAIL rstmid_latency: got %0d expected 64", n); end
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL rstmid_dout_after: got %h expected 5a", dout); end
    oe = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    set_ch(0, 8'h12);
    start = 1'b1; tick();
    checks++; if (eoc !== 1'b0) begin errors++; $display("FAIL b2b_eoc_fall: got %b expected 0", eoc); end
    start = 1'b0; tick();
    wait_eoc(n);
    oe = 1'b1; #1;
    checks++; if (dout !== 8'h12 || n != 64) begin errors++; $display("FAIL b2b_same_ch: got dout=%h n=%0d expected dout=12 n=64", dout, n); end
    oe = 1'b0;
    set_ch(6, 8'hE7);
    addr = 3'd6; ale = 1'b1; start = 1'b1; tick();
    checks++; if (ch_sel !== 3'd6 || eoc !== 1'b0) begin errors++; $display("FAIL b2b_simul: got ch_sel=%0d eoc=%b expected ch_sel=6 eoc=0", ch_sel, eoc); end
    ale = 1'b0; start = 1'b0; tick();
    wait_eoc(n);
    oe = 1'b1; #1;
    checks++; if (dout !== 8'hE7) begin errors++; $display("FAIL b2b_new_ch: got %h expected e7", dout); end
    oe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_channels();
    test_sample_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
